// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, opcode
// field width, default fetch constants, FSM state encoding and address helper.
package fetch_unit_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 7;

    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_HALT_WORD = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_PC_STEP   = 32'd4;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        FULL  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). One outstanding request at a time.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word and its PC. Used when a word
// returns while the IF/ID register is occupied and the decoder is stalled.
// Flush has priority over load, load over unload.
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [XLEN-1:0] word_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            full,
    output logic [XLEN-1:0] word_out,
    output logic [XLEN-1:0] pc_out
);

    logic            full_q, full_d;
    logic [XLEN-1:0] word_q, word_d;
    logic [XLEN-1:0] pc_q,   pc_d;

    // Next-entry selection: flush empties, load captures, unload releases.
    always_comb begin
        full_d = full_q;
        word_d = word_q;
        pc_d   = pc_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            word_d = word_in;
            pc_d   = pc_in;
        end else if (unload) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            word_q <= 32'h0000_0000;
            pc_q   <= 32'h0000_0000;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
            pc_q   <= pc_d;
        end
    end

    assign full     = full_q;
    assign word_out = word_q;
    assign pc_out   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the main control decoder. Keeps the PC,
// issues one request at a time, captures words into the IF/ID register and
// handles stall, branch redirect/flush and halt-word detection.
// Optional build macro FETCH_ALIGN_CHECK_EN: a redirect to a non-word-aligned
// target halts the stage and raises fetch_misaligned instead of masking.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [XLEN-1:0] HALT_WORD = DEF_HALT_WORD,
    parameter logic [XLEN-1:0] PC_STEP   = DEF_PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     imem,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr_out,
    output logic [OPC_W-1:0] opcode,
    output logic [XLEN-1:0]  pc_out,
    output logic             halted,
    output logic             fetch_misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic            ivalid_q, ivalid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcout_q, pcout_d;
    logic            halted_q, halted_d;
    logic            misal_q, misal_d;

    logic            misal_branch_s;
    logic            skid_load_s, skid_unload_s, skid_flush_s;
    logic            skid_full_s;
    logic [XLEN-1:0] skid_word_s, skid_pc_s;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load_s),
        .unload   (skid_unload_s),
        .flush    (skid_flush_s),
        .word_in  (imem.imem_rdata),
        .pc_in    (pc_q),
        .full     (skid_full_s),
        .word_out (skid_word_s),
        .pc_out   (skid_pc_s)
    );

    // Next-state, PC and IF/ID computation; redirect outranks every other event.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ivalid_d      = ivalid_q & stall;
        instr_d       = instr_q;
        pcout_d       = pcout_q;
        halted_d      = halted_q;
        misal_d       = misal_q;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_flush_s  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misal_branch_s = (branch_target[1:0] != 2'b00);
`else
        misal_branch_s = 1'b0;
`endif
        if (branch_taken && (state_q != HALT)) begin
            ivalid_d     = 1'b0;
            skid_flush_s = 1'b1;
            if (misal_branch_s) begin
                misal_d  = 1'b1;
                halted_d = 1'b1;
                state_d  = HALT;
            end else if (((state_q == WAIT) || (state_q == DRAIN)) && !imem.imem_ready) begin
                // A response is still in flight; it must be swallowed first.
                pc_d    = word_align(branch_target);
                state_d = DRAIN;
            end else begin
                pc_d    = word_align(branch_target);
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (!imem.imem_ready) begin
                        state_d = WAIT;
                    end else if (imem.imem_rdata == HALT_WORD) begin
                        halted_d = 1'b1;
                        ivalid_d = 1'b0;
                        state_d  = HALT;
                    end else if (!ivalid_q || !stall) begin
                        ivalid_d = 1'b1;
                        instr_d  = imem.imem_rdata;
                        pcout_d  = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = FETCH;
                    end else begin
                        skid_load_s = 1'b1;
                        pc_d        = pc_q + PC_STEP;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        skid_unload_s = 1'b1;
                        ivalid_d      = skid_full_s;
                        instr_d       = skid_word_s;
                        pcout_d       = skid_pc_s;
                        state_d       = FETCH;
                    end else begin
                        state_d = FULL;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                HALT: begin
                    ivalid_d = 1'b0;
                    state_d  = HALT;
                end
                default: begin
                    ivalid_d     = 1'b0;
                    skid_flush_s = 1'b1;
                    state_d      = FETCH;
                end
            endcase
        end
        req_d = (state_d == FETCH) || (state_d == WAIT);
    end

    // Stage registers; reset returns to a clean FETCH at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            ivalid_q <= 1'b0;
            instr_q  <= 32'h0000_0000;
            pcout_q  <= 32'h0000_0000;
            halted_q <= 1'b0;
            misal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            ivalid_q <= ivalid_d;
            instr_q  <= instr_d;
            pcout_q  <= pcout_d;
            halted_q <= halted_d;
            misal_q  <= misal_d;
        end
    end

    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = pc_q;
    assign instr_valid     = ivalid_q;
    assign instr_out       = instr_q;
    assign opcode          = instr_q[OPC_W-1:0];
    assign pc_out          = pcout_q;
    assign halted          = halted_q;
    assign fetch_misaligned = misal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table covering the basic
// fetch/halt program, stall into the skid buffer and a redirect colliding with
// a response, followed by hand sequences for async reset mid-request,
// DRAIN, PC wrap and misaligned redirect.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [6:0]  opcode;
    logic [31:0] pc_out;
    logic        halted;
    logic        fetch_misaligned;

    int errors;
    int checks;

    fetch_unit_if imem_bus ();

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imem_bus),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .instr_valid      (instr_valid),
        .instr_out        (instr_out),
        .opcode           (opcode),
        .pc_out           (pc_out),
        .halted           (halted),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic rd, input logic [31:0] rdat,
                       input logic eq, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep, input logic eh);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.rdy = rd; v.rdata = rdat;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_halt = eh;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t,
                         input logic rd, input logic [31:0] rdat);
        stall = s;
        branch_taken = b;
        branch_target = t;
        imem_bus.imem_ready = rd;
        imem_bus.imem_rdata = rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] W1 = 32'h0050_0093;
    localparam logic [31:0] W2 = 32'h00A0_0113;
    localparam logic [31:0] WA = 32'h0010_0013;
    localparam logic [31:0] WB = 32'h0020_0013;
    localparam logic [31:0] WC = 32'h0030_0013;
    localparam logic [31:0] WD = 32'h0040_0013;
    localparam logic [31:0] WE = 32'h0050_0013;
    localparam logic [31:0] WF = 32'h0060_0013;
    localparam logic [31:0] WG = 32'h0070_0013;
    localparam logic [31:0] WH = 32'h0080_0013;
    localparam logic [31:0] Z  = 32'h0000_0000;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, Z, 1'b0, Z);

        // rst stall br tgt rdy rdata | req addr valid instr pc_out halted
        // Program 0x00500093, 0x00A00113, halt word; redirect ignored in HALT.
        add(0,0,0,Z,0,Z,              0,32'h00,0,Z ,Z,0);
        add(0,0,0,Z,0,Z,              1,32'h00,0,Z ,Z,0);
        add(0,0,0,Z,1,W1,             1,32'h00,0,Z ,Z,0);
        add(0,0,0,Z,0,Z,              1,32'h04,1,W1,32'h0,0);
        add(0,0,0,Z,1,W2,             1,32'h04,0,W1,32'h0,0);
        add(0,0,0,Z,0,Z,              1,32'h08,1,W2,32'h4,0);
        add(0,0,0,Z,1,Z,              1,32'h08,0,W2,32'h4,0);
        add(0,0,1,32'h40,0,Z,         0,32'h08,0,W2,32'h4,1);
        add(0,0,0,Z,0,Z,              0,32'h08,0,W2,32'h4,1);
        add(1,0,0,Z,0,Z,              0,32'h08,0,W2,32'h4,1);
        // Fresh run: stall into skid buffer, then redirect with a response.
        add(0,0,0,Z,0,Z,              0,32'h00,0,Z ,Z,0);
        add(0,0,0,Z,0,Z,              1,32'h00,0,Z ,Z,0);
        add(0,0,0,Z,1,WA,             1,32'h00,0,Z ,Z,0);
        add(0,0,0,Z,0,Z,              1,32'h04,1,WA,32'h0,0);
        add(0,0,0,Z,1,WB,             1,32'h04,0,WA,32'h0,0);
        add(0,0,0,Z,0,Z,              1,32'h08,1,WB,32'h4,0);
        add(0,0,0,Z,1,WC,             1,32'h08,0,WB,32'h4,0);
        add(0,1,0,Z,0,Z,              1,32'h0C,1,WC,32'h8,0);
        add(0,1,0,Z,1,WD,             1,32'h0C,1,WC,32'h8,0);
        add(0,1,0,Z,0,Z,              0,32'h10,1,WC,32'h8,0);
        add(0,1,0,Z,0,Z,              0,32'h10,1,WC,32'h8,0);
        add(0,1,0,Z,0,Z,              0,32'h10,1,WC,32'h8,0);
        add(0,0,0,Z,0,Z,              0,32'h10,1,WC,32'h8,0);
        add(0,0,0,Z,0,Z,              1,32'h10,1,WD,32'hC,0);
        add(0,0,0,Z,0,Z,              1,32'h10,0,WD,32'hC,0);
        add(0,0,1,32'h40,1,WE,        1,32'h10,0,WD,32'hC,0);
        add(0,0,0,Z,0,Z,              1,32'h40,0,WD,32'hC,0);
        add(0,0,0,Z,1,WF,             1,32'h40,0,WD,32'hC,0);
        add(0,1,1,32'h80,0,Z,         1,32'h44,1,WF,32'h40,0);
        add(0,0,0,Z,0,Z,              1,32'h80,0,WF,32'h40,0);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("row%0d imem_req", i),    {31'd0, imem_bus.imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("row%0d imem_addr", i),   imem_bus.imem_addr,        vecs[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid},      {31'd0, vecs[i].e_valid});
            chk($sformatf("row%0d instr_out", i),   instr_out,                 vecs[i].e_instr);
            chk($sformatf("row%0d opcode", i),      {25'd0, opcode},           {25'd0, vecs[i].e_instr[6:0]});
            chk($sformatf("row%0d pc_out", i),      pc_out,                    vecs[i].e_pc);
            chk($sformatf("row%0d halted", i),      {31'd0, halted},           {31'd0, vecs[i].e_halt});
            chk($sformatf("row%0d misaligned", i),  {31'd0, fetch_misaligned}, 32'd0);
            rst = vecs[i].rst;
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
            tick();
        end

        // Asynchronous reset in the middle of a WAIT cycle (request to 0x80 pending).
        chk("pre_reset req", {31'd0, imem_bus.imem_req}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst req",   {31'd0, imem_bus.imem_req}, 32'd0);
        chk("async_rst addr",  imem_bus.imem_addr, 32'h0000_0000);
        chk("async_rst valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst instr", instr_out, 32'h0000_0000);
        chk("async_rst pc",    pc_out, 32'h0000_0000);
        chk("async_rst halt",  {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int n;
            n = 0;
            while (!imem_bus.imem_req && n < 10) begin
                tick();
                n++;
            end
            chk("post_reset req seen", {31'd0, imem_bus.imem_req}, 32'd1);
            chk("post_reset addr", imem_bus.imem_addr, 32'h0000_0000);
        end

        // Redirect while waiting on a slow response: DRAIN swallows it.
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, Z);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
        chk("drain req",   {31'd0, imem_bus.imem_req}, 32'd0);
        chk("drain valid", {31'd0, instr_valid}, 32'd0);
        drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, Z);
        tick();
        chk("drain rebranch req",  {31'd0, imem_bus.imem_req}, 32'd0);
        chk("drain rebranch addr", imem_bus.imem_addr, 32'h0000_0200);
        drive(1'b0, 1'b0, Z, 1'b1, 32'h0BAD_0013);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
        chk("after drain req",   {31'd0, imem_bus.imem_req}, 32'd1);
        chk("after drain addr",  imem_bus.imem_addr, 32'h0000_0200);
        chk("after drain valid", {31'd0, instr_valid}, 32'd0);
        tick();
        drive(1'b0, 1'b0, Z, 1'b1, WG);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
        chk("target instr valid", {31'd0, instr_valid}, 32'd1);
        chk("target instr",       instr_out, WG);
        chk("target pc",          pc_out, 32'h0000_0200);

        // PC wrap: fetch at 0xFFFF_FFFC, next request address is 0.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, Z);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
        chk("wrap addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, Z, 1'b1, WH);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
        chk("wrap pc_out",    pc_out, 32'hFFFF_FFFC);
        chk("wrap next addr", imem_bus.imem_addr, 32'h0000_0000);
        tick();

        // Misaligned redirect from WAIT.
        drive(1'b0, 1'b1, 32'h0000_0042, 1'b0, Z);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misal flag",  {31'd0, fetch_misaligned}, 32'd1);
        chk("misal halted", {31'd0, halted}, 32'd1);
        chk("misal req",   {31'd0, imem_bus.imem_req}, 32'd0);
        tick();
        chk("misal sticky", {31'd0, halted & fetch_misaligned}, 32'd1);
        chk("misal no req", {31'd0, imem_bus.imem_req}, 32'd0);
`else
        chk("mask flag", {31'd0, fetch_misaligned}, 32'd0);
        chk("mask addr", imem_bus.imem_addr, 32'h0000_0040);
        chk("mask req",  {31'd0, imem_bus.imem_req}, 32'd0);
        drive(1'b0, 1'b0, Z, 1'b1, Z);
        tick();
        drive(1'b0, 1'b0, Z, 1'b0, Z);
        chk("mask fetch req",  {31'd0, imem_bus.imem_req}, 32'd1);
        chk("mask fetch addr", imem_bus.imem_addr, 32'h0000_0040);
        chk("mask not halted", {31'd0, halted}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
